pipeline_hazard_controller: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It generates per-stage stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and computes EX-stage forwarding selects. It tracks data-memory wait states with a timeout FSM and keeps saturating stall and flush statistics. It sits beside the pipeline registers in the core top level; the ID/EX and EX/MEM registers gain stall inputs driven from this block.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/pipeline_hazard_controller_sat_counter.sv | 33 +++
 rtl/pipeline_hazard_controller.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Operand source select; the younger MEM result wins over WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing, EX forwarding selects and memory-wait timeout
// supervision for the 5-stage pipeline.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ID_Rs1,
  input  logic [4:0]           ID_Rs2,
  input  logic [4:0]           EX_Rs1,
  input  logic [4:0]           EX_Rs2,
  input  logic [4:0]           EX_Rd,
  input  logic                 EX_MemRead,
  input  logic                 EX_Redirect,
  input  logic [4:0]           MEM_Rd,
  input  logic                 MEM_RegWrite,
  input  logic                 Mem_Req,
  input  logic                 Mem_Ready,
  input  logic [4:0]           WB_Rd,
  input  logic                 WB_RegWrite,
  output logic                 Pc_Stall,
  output logic                 Pc_Redirect,
  output logic                 IF_ID_Stall,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Stall,
  output logic                 ID_EX_Flush,
  output logic                 EX_MEM_Stall,
  output logic                 MEM_WB_Flush,
  output logic [1:0]           ForwardA,
  output logic [1:0]           ForwardB,
  output logic                 Mem_Timeout,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] FlushEvents
);

  // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              mem_stall;
  logic              load_use;

  // Next-state logic for the memory-wait supervisor.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (Mem_Req && !Mem_Ready) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (Mem_Ready) begin
          state_d = RUN;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Zero-latency stall/flush priority and forwarding selects.
  always_comb begin
    Pc_Stall     = 1'b0;
    Pc_Redirect  = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Stall = 1'b0;
    MEM_WB_Flush = 1'b0;
    ForwardA     = FWD_RF;
    ForwardB     = FWD_RF;
    mem_stall    = (Mem_Req && !Mem_Ready) || (state_q == ERROR);
    load_use     = EX_MemRead && (EX_Rd != 5'd0) &&
                   ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2));
    if (reset) begin
      ForwardA = fwd_sel(EX_Rs1, MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite);
      ForwardB = fwd_sel(EX_Rs2, MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite);
      if (mem_stall) begin
        Pc_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Stall = 1'b1;
        MEM_WB_Flush = 1'b1;
      end else if (EX_Redirect) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        Pc_Redirect = 1'b1;
      end else if (load_use) begin
        Pc_Stall    = 1'b1;
        IF_ID_Stall = 1'b1;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  assign Mem_Timeout = timeout_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (Pc_Stall),
    .count (StallCycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (IF_ID_Flush | ID_EX_Flush),
    .count (FlushEvents)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (CNT_WIDTH=4, MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs1, ID_Rs2, EX_Rs1, EX_Rs2, EX_Rd, MEM_Rd, WB_Rd;
  logic       EX_MemRead, EX_Redirect, MEM_RegWrite, Mem_Req, Mem_Ready, WB_RegWrite;
  logic       Pc_Stall, Pc_Redirect, IF_ID_Stall, IF_ID_Flush;
  logic       ID_EX_Stall, ID_EX_Flush, EX_MEM_Stall, MEM_WB_Flush, Mem_Timeout;
  logic [1:0] ForwardA, ForwardB;
  logic [3:0] StallCycles, FlushEvents;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_Rs1       (ID_Rs1),
    .ID_Rs2       (ID_Rs2),
    .EX_Rs1       (EX_Rs1),
    .EX_Rs2       (EX_Rs2),
    .EX_Rd        (EX_Rd),
    .EX_MemRead   (EX_MemRead),
    .EX_Redirect  (EX_Redirect),
    .MEM_Rd       (MEM_Rd),
    .MEM_RegWrite (MEM_RegWrite),
    .Mem_Req      (Mem_Req),
    .Mem_Ready    (Mem_Ready),
    .WB_Rd        (WB_Rd),
    .WB_RegWrite  (WB_RegWrite),
    .Pc_Stall     (Pc_Stall),
    .Pc_Redirect  (Pc_Redirect),
    .IF_ID_Stall  (IF_ID_Stall),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Stall  (ID_EX_Stall),
    .ID_EX_Flush  (ID_EX_Flush),
    .EX_MEM_Stall (EX_MEM_Stall),
    .MEM_WB_Flush (MEM_WB_Flush),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .Mem_Timeout  (Mem_Timeout),
    .StallCycles  (StallCycles),
    .FlushEvents  (FlushEvents)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_Rs1 = '0; ID_Rs2 = '0; EX_Rs1 = '0; EX_Rs2 = '0; EX_Rd = '0;
    MEM_Rd = '0; WB_Rd = '0;
    EX_MemRead = 1'b0; EX_Redirect = 1'b0; MEM_RegWrite = 1'b0;
    Mem_Req = 1'b0; Mem_Ready = 1'b0; WB_RegWrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #2;
    // Outputs forced low while reset is held, even with hazards on the inputs.
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5;
    EX_Rs1 = 5'd7; MEM_Rd = 5'd7; MEM_RegWrite = 1'b1;
    #1;
    chk("rst_pc_stall", Pc_Stall, 0);
    chk("rst_idex_flush", ID_EX_Flush, 0);
    chk("rst_fwda", ForwardA, 2'b00);
    chk("rst_stallcnt", StallCycles, 0);
    chk("rst_timeout", Mem_Timeout, 0);
    do_reset();

    // Load-use: exactly one bubble.
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5;
    #1;
    chk("lu_pc_stall", Pc_Stall, 1);
    chk("lu_ifid_stall", IF_ID_Stall, 1);
    chk("lu_idex_flush", ID_EX_Flush, 1);
    chk("lu_idex_stall", ID_EX_Stall, 0);
    chk("lu_ifid_flush", IF_ID_Flush, 0);
    tick();
    clear_inputs();
    #1;
    chk("lu_stallcnt", StallCycles, 1);
    chk("lu_flushcnt", FlushEvents, 1);
    chk("lu_released", Pc_Stall, 0);

    // Load from x0 never creates a load-use hazard.
    EX_MemRead = 1'b1; EX_Rd = 5'd0; ID_Rs1 = 5'd0;
    #1;
    chk("lu_x0", Pc_Stall, 0);
    clear_inputs();

    // Redirect outranks load-use.
    EX_Redirect = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3;
    #1;
    chk("rd_ifid_flush", IF_ID_Flush, 1);
    chk("rd_idex_flush", ID_EX_Flush, 1);
    chk("rd_pc_redirect", Pc_Redirect, 1);
    chk("rd_pc_stall", Pc_Stall, 0);
    clear_inputs();

    // Memory wait with a pending redirect held in EX.
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0; EX_Redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_pc_stall", Pc_Stall, 1);
      chk("mw_exmem_stall", EX_MEM_Stall, 1);
      chk("mw_idex_stall", ID_EX_Stall, 1);
      chk("mw_memwb_flush", MEM_WB_Flush, 1);
      chk("mw_pc_redirect", Pc_Redirect, 0);
      tick();
    end
    Mem_Ready = 1'b1;
    #1;
    chk("mw_release_stall", Pc_Stall, 0);
    chk("mw_release_redirect", Pc_Redirect, 1);
    chk("mw_stallcnt", StallCycles, 3);
    tick();
    clear_inputs();
    #1;
    chk("mw_flushcnt", FlushEvents, 1);
    chk("mw_run_no_stall", Pc_Stall, 0);

    // Timeout: four MEM_WAIT cycles without ready enter ERROR.
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("to_not_yet", Mem_Timeout, 0);
    tick();
    chk("to_set", Mem_Timeout, 1);
    Mem_Ready = 1'b1;
    tick();
    #1;
    chk("to_sticky", Mem_Timeout, 1);
    chk("to_err_stall", Pc_Stall, 1);
    chk("to_err_memwb", MEM_WB_Flush, 1);
    reset = 1'b0;
    #1;
    chk("to_rst_clear", Mem_Timeout, 0);
    chk("to_rst_stall", Pc_Stall, 0);
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
    chk("to_back_run", Pc_Stall, 0);

    // Ready in the same cycle the counter reaches the limit returns to RUN.
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Mem_Ready = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk("edge_no_timeout", Mem_Timeout, 0);
    chk("edge_no_stall", Pc_Stall, 0);

    // Forwarding selects.
    do_reset();
    EX_Rs1 = 5'd7; EX_Rs2 = 5'd7; MEM_Rd = 5'd7; WB_Rd = 5'd7;
    MEM_RegWrite = 1'b1; WB_RegWrite = 1'b1;
    #1;
    chk("fwd_a_mem", ForwardA, 2'b10);
    chk("fwd_b_mem", ForwardB, 2'b10);
    MEM_Rd = 5'd0;
    #1;
    chk("fwd_a_wb", ForwardA, 2'b01);
    chk("fwd_b_wb", ForwardB, 2'b01);
    EX_Rs1 = 5'd0;
    #1;
    chk("fwd_a_x0", ForwardA, 2'b00);
    chk("fwd_b_still_wb", ForwardB, 2'b01);
    WB_RegWrite = 1'b0;
    #1;
    chk("fwd_b_rf", ForwardB, 2'b00);
    // Forwarding continues during a memory stall.
    MEM_Rd = 5'd7; Mem_Req = 1'b1;
    #1;
    chk("fwd_during_stall", ForwardB, 2'b10);
    clear_inputs();

    // Saturation of the 4-bit counters.
    do_reset();
    EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_Rs1 = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    clear_inputs();
    #1;
    chk("sat_stallcnt", StallCycles, 15);
    chk("sat_flushcnt", FlushEvents, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
